// File: rtl/mips_store_checker.sv
// In-order store checker for the single-cycle MIPS data-memory write port: compares CPU
// stores against a preloaded queue of expected (address, data) pairs and reports pass/fail.
module mips_store_checker #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [31:0] WIN_LO  = 32'h14,
    parameter logic [31:0] WIN_HI  = 32'h28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exp_valid,
    input  logic [31:0] exp_addr,
    input  logic [31:0] exp_data,
    output logic        exp_ready,
    input  logic        start,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [7:0]  store_count
);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_PASS, S_FAIL} state_e;

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned TW       = $clog2(TIMEOUT) + 1;
    localparam logic [AW:0] FULL     = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          exp_ready_q, exp_ready_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    sc_q, sc_d;

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   head_addr, head_data;
    logic          push, pop, in_win;

    assign head_addr = addr_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];
    assign in_win    = (aluout[1:0] == 2'b00) && (aluout >= WIN_LO) && (aluout <= WIN_HI);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tmo_d    = tmo_q;
        done_d   = done_q;
        pass_d   = pass_q;
        code_d   = code_q;
        sc_d     = sc_q;
        push     = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                push = exp_valid && (count_q != FULL);
                if (push) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + (AW + 1)'(1);
                end
                // start looks at the occupancy including this edge's push
                if (start && (count_d != '0)) begin
                    state_d = S_RUN;
                    tmo_d   = '0;
                end
            end
            S_RUN: begin
                pop = memwrite && (aluout == head_addr) && (writedata == head_data);
                if (memwrite && (sc_q != 8'hFF)) sc_d = sc_q + 8'd1;
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - (AW + 1)'(1);
                    tmo_d    = '0;
                    if (count_q == (AW + 1)'(1)) begin
                        state_d = S_PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
                end else if (memwrite && !in_win) begin
                    state_d = S_FAIL;
                    done_d  = 1'b1;
                    code_d  = (aluout == head_addr) ? 2'd2 : 2'd1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAIL;
                    done_d  = 1'b1;
                    code_d  = 2'd3;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: ;
        endcase
        exp_ready_d = (state_d == S_LOAD) && (count_d != FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            exp_ready_q <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            code_q      <= '0;
            sc_q        <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            exp_ready_q <= exp_ready_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            code_q      <= code_d;
            sc_q        <= sc_d;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= exp_addr;
            data_mem[wr_ptr_q] <= exp_data;
        end
    end

    assign exp_ready   = exp_ready_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = code_q;
    assign store_count = sc_q;

endmodule

// File: tb/tb_mips_store_checker.sv
// Bench for mips_store_checker: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized load/run sequences.
module tb_mips_store_checker;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int WLO     = 32'h14;
    localparam int WHI     = 32'h28;
    localparam int P_LOAD = 0, P_RUN = 1, P_PASS = 2, P_FAIL = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic        exp_ready;
    logic        start = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] aluout = '0;
    logic [31:0] writedata = '0;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [7:0]  store_count;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    mips_store_checker #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .WIN_LO (32'h14),
        .WIN_HI (32'h28)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .exp_valid  (exp_valid),
        .exp_addr   (exp_addr),
        .exp_data   (exp_data),
        .exp_ready  (exp_ready),
        .start      (start),
        .memwrite   (memwrite),
        .aluout     (aluout),
        .writedata  (writedata),
        .done       (done),
        .pass       (pass),
        .fail_code  (fail_code),
        .store_count(store_count)
    );

    always #5 clk = ~clk;

    // Reference model: expected stores as a FIFO of {addr,data}, plus a phase,
    // the number of consecutive run cycles without a match, and observed store total.
    logic [63:0] m_q[$];
    int m_phase = P_LOAD;
    int m_idle  = 0;
    int m_sc    = 0;
    int m_code  = 0;

    task automatic model_step();
        bit scratch;
        if (m_phase == P_LOAD) begin
            if (exp_valid && m_q.size() < DEPTH) m_q.push_back({exp_addr, exp_data});
            if (start && m_q.size() > 0) begin
                m_phase = P_RUN;
                m_idle  = 0;
            end
        end else if (m_phase == P_RUN) begin
            if (memwrite) m_sc = (m_sc < 255) ? m_sc + 1 : 255;
            if (memwrite && {aluout, writedata} == m_q[0]) begin
                void'(m_q.pop_front());
                m_idle = 0;
                if (m_q.size() == 0) m_phase = P_PASS;
            end else begin
                scratch = (aluout % 4 == 0) && (aluout >= WLO) && (aluout <= WHI);
                if (memwrite && !scratch) begin
                    m_phase = P_FAIL;
                    m_code  = (aluout == m_q[0][63:32]) ? 2 : 1;
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_phase = P_FAIL;
                        m_code  = 3;
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = P_LOAD;
        m_idle  = 0;
        m_sc    = 0;
        m_code  = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_exp_ready", 32'(exp_ready), 32'((m_phase == P_LOAD) && (m_q.size() < DEPTH)));
            cmp("model_done", 32'(done), 32'(m_phase == P_PASS || m_phase == P_FAIL));
            cmp("model_pass", 32'(pass), 32'(m_phase == P_PASS));
            cmp("model_fail_code", 32'(fail_code), 32'(m_code));
            cmp("model_store_count", 32'(store_count), 32'(m_sc));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        exp_valid = 1'b0;
        start = 1'b0;
        memwrite = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        exp_valid = 1'b1;
        exp_addr  = a;
        exp_data  = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, mode, pm;
        logic [31:0] a, d;
        tick();
        #1 reset = 1'b1;
        chk_en = 1'b1;
        tick();
        cmp("reset_exp_ready", 32'(exp_ready), 32'd1);
        cmp("reset_done", 32'(done), 32'd0);
        cmp("reset_store_count", 32'(store_count), 32'd0);

        // 1: scratch-window stores are skipped, then the match passes
        load(32'h10, 32'hfffffffa);
        go();
        for (int i = 0; i < 6; i++) st(32'h14 + 32'(4 * i), $urandom);
        st(32'h10, 32'hfffffffa);
        cmp("t1_pass", 32'(pass), 32'd1);
        cmp("t1_done", 32'(done), 32'd1);
        cmp("t1_code", 32'(fail_code), 32'd0);
        cmp("t1_count", 32'(store_count), 32'd7);

        // 2: unexpected address
        do_reset();
        load(32'h54, 32'h7);
        go();
        st(32'h80, 32'h7);
        cmp("t2_done", 32'(done), 32'd1);
        cmp("t2_pass", 32'(pass), 32'd0);
        cmp("t2_code", 32'(fail_code), 32'd1);
        cmp("t2_count", 32'(store_count), 32'd1);

        // 3: data mismatch at head address
        do_reset();
        load(32'h10, 32'hfffffffa);
        go();
        st(32'h10, 32'h7);
        cmp("t3_code", 32'(fail_code), 32'd2);
        cmp("t3_done", 32'(done), 32'd1);

        // 4: timeout lands exactly TIMEOUT edges after entering run
        do_reset();
        load(32'h40, 32'h1);
        go();
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (i == TIMEOUT - 1) cmp("t4_done_early", 32'(done), 32'd0);
        end
        cmp("t4_done", 32'(done), 32'd1);
        cmp("t4_code", 32'(fail_code), 32'd3);

        // 5: ninth entry dropped; pass only on the eighth match
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            load(32'h100 + 32'(4 * i), 32'(3 * i + 1));
            if (i == DEPTH - 1) cmp("t5_full_ready", 32'(exp_ready), 32'd0);
        end
        go();
        for (int i = 0; i < DEPTH; i++) begin
            st(32'h100 + 32'(4 * i), 32'(3 * i + 1));
            if (i == DEPTH - 2) cmp("t5_pass_7th", 32'(pass), 32'd0);
        end
        cmp("t5_pass_8th", 32'(pass), 32'd1);
        cmp("t5_count", 32'(store_count), 32'd8);

        // 6: asynchronous reset mid-run
        do_reset();
        load(32'h200, 32'h11);
        load(32'h204, 32'h22);
        go();
        st(32'h200, 32'h11);
        #1 reset = 1'b0;
        #1;
        cmp("t6_async_ready", 32'(exp_ready), 32'd1);
        cmp("t6_async_count", 32'(store_count), 32'd0);
        cmp("t6_async_done", 32'(done), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        tick();
        st(32'h204, 32'h22);
        cmp("t6_ignored_count", 32'(store_count), 32'd0);
        cmp("t6_ignored_done", 32'(done), 32'd0);
        cmp("t6_still_load", 32'(exp_ready), 32'd1);

        // randomized load/run sequences against the model
        for (int r = 0; r < 250; r++) begin
            do_reset();
            n = $urandom_range(0, 10);
            if (n == 0) begin
                go();
                n = 1;
            end
            for (int i = 0; i < int'(n); i++) begin
                if ($urandom_range(0, 3) == 0) st($urandom, $urandom);
                d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                load(32'($urandom_range(0, 63)) << 2, d);
            end
            go();
            pm = $urandom_range(20, 80);
            for (int c = 0; c < 40; c++) begin
                mode = $urandom_range(0, 99);
                exp_valid = ($urandom_range(0, 7) == 0);
                exp_addr  = $urandom;
                exp_data  = $urandom;
                start     = ($urandom_range(0, 7) == 0);
                if (m_phase == P_RUN && mode < pm) begin
                    st(m_q[0][63:32], m_q[0][31:0]);
                end else if (mode < pm + 10) begin
                    st(32'($urandom_range(5, 10)) << 2, $urandom);
                end else if (mode < pm + 14 && m_phase == P_RUN) begin
                    st(m_q[0][63:32], m_q[0][31:0] ^ 32'h1);
                end else if (mode < pm + 16) begin
                    a = ($urandom_range(0, 1) == 0) ? 32'h15 : $urandom;
                    st(a, $urandom);
                end else begin
                    tick();
                end
                exp_valid = 1'b0;
                start     = 1'b0;
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
